// File: rtl/conv_ctrl_v2.sv
// conv_ctrl_v2: runtime-configured convolution sequencer (weight load, line buffer, window strobes).
// Optional macro STALL_CNT_EN adds the 32-bit stall_cnt output (stalled busy cycles).
module conv_ctrl_v2 #(
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_IFM     = 64,
    parameter int MAX_CH      = 256,
    parameter int DIM_W       = 7,
    parameter int CH_W        = 9
) (
    input  logic                                 clk1,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [DIM_W-1:0]                     cfg_ifm_size,
    input  logic [2:0]                           cfg_stride,
    input  logic [2:0]                           cfg_pad,
    input  logic [CH_W-1:0]                      cfg_ci,
    input  logic [CH_W-1:0]                      cfg_co,
    input  logic                                 stall,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 cfg_err,
    output logic                                 wgt_read,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   set_wgt,
    output logic                                 ifm_read,
    output logic                                 lb_wr_en,
    output logic [KERNEL_SIZE-1:0]               lb_wr_sel,
    output logic                                 win_valid,
    output logic                                 acc_clr,
    output logic                                 out_valid
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]                          stall_cnt
`endif
);

    // state     | meaning
    // S_IDLE    | waiting for start, config not yet latched
    // S_WLOAD   | K*K weight fetch cycles for the current channel/filter pass
    // S_COMPUTE | raster scan of S*S positions
    // S_DONE    | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_COMPUTE, S_DONE} state_t;

    localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WI_W = (KK > 1) ? $clog2(KK) : 1;
    localparam logic [DIM_W-1:0] L_K      = DIM_W'(KERNEL_SIZE);
    localparam logic [DIM_W-1:0] L_KM1    = DIM_W'(KERNEL_SIZE - 1);
    localparam logic [DIM_W-1:0] L_MAXIFM = DIM_W'(MAX_IFM);
    localparam logic [CH_W-1:0]  L_MAXCH  = CH_W'(MAX_CH);

    state_t            r_state, w_state_nx;
    logic [DIM_W-1:0]  r_size, w_size_nx, r_row, w_row_nx, r_col, w_col_nx;
    logic [2:0]        r_stride, w_stride_nx, r_pad, w_pad_nx, r_rph, w_rph_nx, r_cph, w_cph_nx;
    logic [CH_W-1:0]   r_ci, w_ci_nx, r_co, w_co_nx, r_ch, w_ch_nx, r_flt, w_flt_nx;
    logic [WI_W-1:0]   r_widx, w_widx_nx;
    logic [KERNEL_SIZE-1:0] r_lb_sel, w_lb_sel_nx, r_lb_wr_sel, w_lb_wr_sel_nx;
    logic [KK-1:0]     r_set_wgt, w_set_wgt_nx;
    logic r_busy, w_busy_nx, r_done, w_done_nx, r_cfg_err, w_cfg_err_nx;
    logic r_wgt_read, w_wgt_read_nx, r_ifm_read, w_ifm_read_nx, r_lb_wr_en, w_lb_wr_en_nx;
    logic r_win_valid, w_win_valid_nx, r_acc_clr, w_acc_clr_nx, r_out_valid, w_out_valid_nx;

    logic             w_cfg_ok, w_accept, w_last_col, w_last_row, w_in_img, w_win;
    logic [DIM_W-1:0] w_hi, w_col_inc, w_row_inc;
    logic [2:0]       w_cph_inc, w_rph_inc;

    assign w_cfg_ok = (cfg_ifm_size >= L_K) && (cfg_ifm_size <= L_MAXIFM) &&
                      (cfg_stride != 3'd0) && (DIM_W'({cfg_pad, 1'b0}) < cfg_ifm_size) &&
                      (cfg_ci != '0) && (cfg_ci <= L_MAXCH) &&
                      (cfg_co != '0) && (cfg_co <= L_MAXCH);
    assign w_accept = (r_state == S_IDLE) && start && w_cfg_ok;

    assign w_last_col = (r_col == r_size - DIM_W'(1));
    assign w_last_row = (r_row == r_size - DIM_W'(1));
    assign w_hi       = r_size - DIM_W'(r_pad);
    assign w_in_img   = (r_row >= DIM_W'(r_pad)) && (r_row < w_hi) &&
                        (r_col >= DIM_W'(r_pad)) && (r_col < w_hi);
    // Stride phases restart at K-1 so phase 0 marks a window origin on the stride grid.
    assign w_win      = (r_row >= L_KM1) && (r_col >= L_KM1) && (r_rph == 3'd0) && (r_cph == 3'd0);

    assign w_col_inc = w_last_col ? '0 : r_col + DIM_W'(1);
    assign w_row_inc = w_last_col ? (w_last_row ? '0 : r_row + DIM_W'(1)) : r_row;
    assign w_cph_inc = (w_col_inc <= L_KM1) ? 3'd0 :
                       (r_cph == r_stride - 3'd1) ? 3'd0 : r_cph + 3'd1;
    assign w_rph_inc = !w_last_col ? r_rph :
                       (w_row_inc <= L_KM1) ? 3'd0 :
                       (r_rph == r_stride - 3'd1) ? 3'd0 : r_rph + 3'd1;

    always_comb begin
        w_state_nx     = r_state;
        w_size_nx      = r_size;
        w_stride_nx    = r_stride;
        w_pad_nx       = r_pad;
        w_ci_nx        = r_ci;
        w_co_nx        = r_co;
        w_widx_nx      = r_widx;
        w_row_nx       = r_row;
        w_col_nx       = r_col;
        w_rph_nx       = r_rph;
        w_cph_nx       = r_cph;
        w_ch_nx        = r_ch;
        w_flt_nx       = r_flt;
        w_lb_sel_nx    = r_lb_sel;
        w_busy_nx      = r_busy;
        w_done_nx      = 1'b0;
        w_cfg_err_nx   = r_cfg_err;
        w_wgt_read_nx  = 1'b0;
        w_set_wgt_nx   = '0;
        w_ifm_read_nx  = 1'b0;
        w_lb_wr_en_nx  = 1'b0;
        w_lb_wr_sel_nx = r_lb_wr_sel;
        w_win_valid_nx = 1'b0;
        w_acc_clr_nx   = 1'b0;
        w_out_valid_nx = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_cfg_ok) begin
                        w_state_nx   = S_WLOAD;
                        w_size_nx    = cfg_ifm_size;
                        w_stride_nx  = cfg_stride;
                        w_pad_nx     = cfg_pad;
                        w_ci_nx      = cfg_ci;
                        w_co_nx      = cfg_co;
                        w_widx_nx    = '0;
                        w_row_nx     = '0;
                        w_col_nx     = '0;
                        w_rph_nx     = 3'd0;
                        w_cph_nx     = 3'd0;
                        w_ch_nx      = '0;
                        w_flt_nx     = '0;
                        w_busy_nx    = 1'b1;
                        w_cfg_err_nx = 1'b0;
                    end else begin
                        w_cfg_err_nx = 1'b1;
                    end
                end
            end
            S_WLOAD: begin
                if (stall) begin
                    w_set_wgt_nx = r_set_wgt;
                end else begin
                    w_wgt_read_nx = 1'b1;
                    w_set_wgt_nx  = {{(KK-1){1'b0}}, 1'b1} << r_widx;
                    if (r_widx == WI_W'(KK - 1)) begin
                        w_widx_nx   = '0;
                        w_state_nx  = S_COMPUTE;
                        w_row_nx    = '0;
                        w_col_nx    = '0;
                        w_rph_nx    = 3'd0;
                        w_cph_nx    = 3'd0;
                        w_lb_sel_nx = {{(KERNEL_SIZE-1){1'b0}}, 1'b1};
                    end else begin
                        w_widx_nx = r_widx + WI_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (stall) begin
                    w_set_wgt_nx = r_set_wgt;
                end else begin
                    w_lb_wr_en_nx  = 1'b1;
                    w_lb_wr_sel_nx = r_lb_sel;
                    w_ifm_read_nx  = w_in_img;
                    w_win_valid_nx = w_win;
                    w_acc_clr_nx   = w_win && (r_ch == '0);
                    w_out_valid_nx = w_win && (r_ch == r_ci - CH_W'(1));
                    w_col_nx       = w_col_inc;
                    w_row_nx       = w_row_inc;
                    w_cph_nx       = w_cph_inc;
                    w_rph_nx       = w_rph_inc;
                    if (w_last_col)
                        w_lb_sel_nx = {r_lb_sel[KERNEL_SIZE-2:0], r_lb_sel[KERNEL_SIZE-1]};
                    if (w_last_col && w_last_row) begin
                        if (r_ch < r_ci - CH_W'(1)) begin
                            w_ch_nx    = r_ch + CH_W'(1);
                            w_state_nx = S_WLOAD;
                        end else if (r_flt < r_co - CH_W'(1)) begin
                            w_ch_nx    = '0;
                            w_flt_nx   = r_flt + CH_W'(1);
                            w_state_nx = S_WLOAD;
                        end else begin
                            w_state_nx = S_DONE;
                            w_busy_nx  = 1'b0;
                            w_done_nx  = 1'b1;
                        end
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_size      <= '0;
            r_stride    <= '0;
            r_pad       <= '0;
            r_ci        <= '0;
            r_co        <= '0;
            r_widx      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_rph       <= '0;
            r_cph       <= '0;
            r_ch        <= '0;
            r_flt       <= '0;
            r_lb_sel    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_wgt_read  <= 1'b0;
            r_set_wgt   <= '0;
            r_ifm_read  <= 1'b0;
            r_lb_wr_en  <= 1'b0;
            r_lb_wr_sel <= '0;
            r_win_valid <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_size      <= w_size_nx;
            r_stride    <= w_stride_nx;
            r_pad       <= w_pad_nx;
            r_ci        <= w_ci_nx;
            r_co        <= w_co_nx;
            r_widx      <= w_widx_nx;
            r_row       <= w_row_nx;
            r_col       <= w_col_nx;
            r_rph       <= w_rph_nx;
            r_cph       <= w_cph_nx;
            r_ch        <= w_ch_nx;
            r_flt       <= w_flt_nx;
            r_lb_sel    <= w_lb_sel_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_cfg_err   <= w_cfg_err_nx;
            r_wgt_read  <= w_wgt_read_nx;
            r_set_wgt   <= w_set_wgt_nx;
            r_ifm_read  <= w_ifm_read_nx;
            r_lb_wr_en  <= w_lb_wr_en_nx;
            r_lb_wr_sel <= w_lb_wr_sel_nx;
            r_win_valid <= w_win_valid_nx;
            r_acc_clr   <= w_acc_clr_nx;
            r_out_valid <= w_out_valid_nx;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign wgt_read  = r_wgt_read;
    assign set_wgt   = r_set_wgt;
    assign ifm_read  = r_ifm_read;
    assign lb_wr_en  = r_lb_wr_en;
    assign lb_wr_sel = r_lb_wr_sel;
    assign win_valid = r_win_valid;
    assign acc_clr   = r_acc_clr;
    assign out_valid = r_out_valid;

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_accept)
            r_stall_cnt <= '0;
        else if (r_busy && stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_conv_ctrl_v2.sv
// Self-checking bench for conv_ctrl_v2 (K=3): per-pixel and per-weight scoreboard plus layer totals.
// Build with STALL_CNT_EN defined to also check the stall counter.
module tb_conv_ctrl_v2;

    logic       clk1, rst_n, start, stall;
    logic [6:0] cfg_ifm_size;
    logic [2:0] cfg_stride, cfg_pad;
    logic [8:0] cfg_ci, cfg_co;
    logic       busy, done, cfg_err, wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid;
    logic [8:0] set_wgt;
    logic [2:0] lb_wr_sel;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    conv_ctrl_v2 dut (
        .clk1(clk1), .rst_n(rst_n), .start(start),
        .cfg_ifm_size(cfg_ifm_size), .cfg_stride(cfg_stride), .cfg_pad(cfg_pad),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co), .stall(stall),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .wgt_read(wgt_read), .set_wgt(set_wgt), .ifm_read(ifm_read),
        .lb_wr_en(lb_wr_en), .lb_wr_sel(lb_wr_sel), .win_valid(win_valid),
        .acc_clr(acc_clr), .out_valid(out_valid)
`ifdef STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int n_chk = 0;
    int n_fail = 0;
    int cnt_busy, cnt_done, cnt_wgt, cnt_lb, cnt_ifm, cnt_win, cnt_acc, cnt_ov;
    logic [8:0] wq[$];
    logic [6:0] pq[$];
    logic stall_q = 1'b0;

    always @(posedge clk1) stall_q <= stall;

    // Monitor: pops expected weight selects and per-pixel strobe bundles as the DUT emits them.
    always @(negedge clk1) begin
        logic [8:0] ew;
        logic [6:0] ep;
        cnt_busy = cnt_busy + int'(busy);
        cnt_done = cnt_done + int'(done);
        cnt_ifm  = cnt_ifm + int'(ifm_read);
        cnt_win  = cnt_win + int'(win_valid);
        cnt_acc  = cnt_acc + int'(acc_clr);
        cnt_ov   = cnt_ov + int'(out_valid);
        if (stall_q) begin
            n_chk++;
            if ({wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid} !== 6'b0) begin
                n_fail++;
                $display("FAIL stall_strobes: got %b want 000000",
                         {wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid});
            end
        end
        if (wgt_read) begin
            cnt_wgt++;
            n_chk++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL wgt_unexpected: got set_wgt=%b want no wgt_read", set_wgt);
            end else begin
                ew = wq.pop_front();
                if (set_wgt !== ew) begin
                    n_fail++;
                    $display("FAIL set_wgt: got %b want %b", set_wgt, ew);
                end
            end
        end
        n_chk++;
        if (lb_wr_en) begin
            cnt_lb++;
            if (pq.size() == 0) begin
                n_fail++;
                $display("FAIL pixel_unexpected: got lb_wr_en=1 want 0");
            end else begin
                ep = pq.pop_front();
                if ({ifm_read, lb_wr_sel, win_valid, acc_clr, out_valid} !== ep) begin
                    n_fail++;
                    $display("FAIL pixel {ifm,sel,win,acc,ov}: got %b want %b",
                             {ifm_read, lb_wr_sel, win_valid, acc_clr, out_valid}, ep);
                end
            end
        end else if ({ifm_read, win_valid, acc_clr, out_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL strobe_without_lb_wr_en: got %b want 0000",
                     {ifm_read, win_valid, acc_clr, out_valid});
        end
    end

    task automatic clr_cnt();
        cnt_busy = 0; cnt_done = 0; cnt_wgt = 0; cnt_lb = 0;
        cnt_ifm = 0; cnt_win = 0; cnt_acc = 0; cnt_ov = 0;
    endtask

    // Reference model of one layer: pushes weight selects and per-pixel strobe bundles.
    task automatic push_layer(input int s, input int st, input int p, input int ci, input int co);
        logic [8:0] one9;
        logic [2:0] one3;
        one9 = 9'd1;
        one3 = 3'd1;
        for (int f = 0; f < co; f++) begin
            for (int c = 0; c < ci; c++) begin
                for (int i = 0; i < 9; i++) wq.push_back(one9 << i);
                for (int r = 0; r < s; r++) begin
                    for (int cc = 0; cc < s; cc++) begin
                        logic ifm, win;
                        logic [2:0] sel;
                        ifm = (r >= p) && (r < s - p) && (cc >= p) && (cc < s - p);
                        win = (r >= 2) && (cc >= 2) && ((r - 2) % st == 0) && ((cc - 2) % st == 0);
                        sel = one3 << (r % 3);
                        pq.push_back({ifm, sel, win, win && (c == 0), win && (c == ci - 1)});
                    end
                end
            end
        end
    endtask

    task automatic drive_cfg(input int s, input int st, input int p, input int ci, input int co);
        cfg_ifm_size = s[6:0];
        cfg_stride   = st[2:0];
        cfg_pad      = p[2:0];
        cfg_ci       = ci[8:0];
        cfg_co       = co[8:0];
    endtask

    task automatic start_layer(input int s, input int st, input int p, input int ci, input int co);
        @(posedge clk1); #1;
        drive_cfg(s, st, p, ci, co);
        start = 1'b1;
        push_layer(s, st, p, ci, co);
        clr_cnt();
        @(posedge clk1); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        int n;
        n = 0;
        to = 1'b0;
        while (done !== 1'b1) begin
            @(negedge clk1);
            n++;
            if (n > budget) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk1);
        n_chk++;
        if ({busy, done, cfg_err} !== 3'b0) begin
            n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, cfg_err});
        end
        n_chk++;
        if ({wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000000",
                               {wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid});
        end
        n_chk++;
        if ({set_wgt, lb_wr_sel} !== 12'b0) begin
            n_fail++; $display("FAIL reset_selects: got %b want 0", {set_wgt, lb_wr_sel});
        end
`ifdef STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        @(posedge clk1); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit to;
        start_layer(5, 1, 1, 1, 1);
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 34) begin n_fail++; $display("FAIL basic_busy: got %0d want 34", cnt_busy); end
        n_chk++;
        if ({cnt_done, cnt_wgt, cnt_lb, cnt_ifm} != {32'd1, 32'd9, 32'd25, 32'd9}) begin
            n_fail++; $display("FAIL basic_counts done/wgt/lb/ifm: got %0d/%0d/%0d/%0d want 1/9/25/9",
                               cnt_done, cnt_wgt, cnt_lb, cnt_ifm);
        end
        n_chk++;
        if (cnt_ov != 9 || cnt_acc != 9) begin
            n_fail++; $display("FAIL basic_ov_acc: got %0d/%0d want 9/9", cnt_ov, cnt_acc);
        end
        n_chk++;
        if (wq.size() != 0 || pq.size() != 0) begin
            n_fail++; $display("FAIL basic_leftover: got %0d/%0d want 0/0", wq.size(), pq.size());
        end
    endtask

    task automatic test_multi_channel();
        bit to;
        start_layer(7, 2, 1, 2, 2);
        wait_done(600, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL multi_timeout: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 232) begin n_fail++; $display("FAIL multi_busy: got %0d want 232", cnt_busy); end
        n_chk++;
        if (cnt_win != 36 || cnt_ov != 18 || cnt_acc != 18) begin
            n_fail++; $display("FAIL multi_win/ov/acc: got %0d/%0d/%0d want 36/18/18", cnt_win, cnt_ov, cnt_acc);
        end
        n_chk++;
        if (cnt_wgt != 36 || cnt_lb != 196 || cnt_done != 1) begin
            n_fail++; $display("FAIL multi_wgt/lb/done: got %0d/%0d/%0d want 36/196/1", cnt_wgt, cnt_lb, cnt_done);
        end
    endtask

    task automatic test_stall();
        bit to;
        start_layer(5, 1, 1, 1, 1);
        repeat (15) @(posedge clk1);
        #1 stall = 1'b1;
        repeat (5) @(posedge clk1);
        #1 stall = 1'b0;
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL stall_timeout: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 39) begin n_fail++; $display("FAIL stall_busy: got %0d want 39", cnt_busy); end
        n_chk++;
        if (cnt_wgt != 9 || cnt_lb != 25 || cnt_ifm != 9 || cnt_ov != 9) begin
            n_fail++; $display("FAIL stall_totals wgt/lb/ifm/ov: got %0d/%0d/%0d/%0d want 9/25/9/9",
                               cnt_wgt, cnt_lb, cnt_ifm, cnt_ov);
        end
`ifdef STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
`endif
    endtask

    task automatic test_cfg_err();
        bit to;
        @(posedge clk1); #1;
        drive_cfg(2, 1, 0, 1, 1);
        start = 1'b1;
        @(posedge clk1); #1;
        start = 1'b0;
        @(negedge clk1);
        n_chk++;
        if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_set: got %b want 1", cfg_err); end
        repeat (3) @(negedge clk1);
        n_chk++;
        if ({busy, cfg_err} !== 2'b01) begin
            n_fail++; $display("FAIL cfg_err_idle busy/err: got %b want 01", {busy, cfg_err});
        end
        start_layer(5, 1, 1, 1, 1);
        @(negedge clk1);
        n_chk++;
        if ({busy, cfg_err} !== 2'b10) begin
            n_fail++; $display("FAIL cfg_err_clear busy/err: got %b want 10", {busy, cfg_err});
        end
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL cfg_err_timeout: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 34 || cnt_ov != 9) begin
            n_fail++; $display("FAIL cfg_err_run busy/ov: got %0d/%0d want 34/9", cnt_busy, cnt_ov);
        end
`ifdef STALL_CNT_EN
        n_chk++;
        if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL stall_cnt_clear: got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        bit to;
        start_layer(5, 1, 1, 1, 1);
        repeat (15) @(posedge clk1);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_busy: got %b want 1", busy); end
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, cfg_err, wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid,
             set_wgt, lb_wr_sel} !== 21'b0) begin
            n_fail++; $display("FAIL rmid_async_clear: got %b want 0",
                {busy, done, cfg_err, wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid,
                 set_wgt, lb_wr_sel});
        end
        wq.delete();
        pq.delete();
        clr_cnt();
        repeat (3) @(negedge clk1);
        @(posedge clk1); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk1);
        n_chk++;
        if (cnt_done != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rmid_no_done done/busy: got %0d/%b want 0/0", cnt_done, busy);
        end
        start_layer(5, 1, 1, 1, 1);
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL rmid_timeout: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 34 || cnt_lb != 25 || cnt_ov != 9 || cnt_done != 1) begin
            n_fail++; $display("FAIL rmid_rerun busy/lb/ov/done: got %0d/%0d/%0d/%0d want 34/25/9/1",
                               cnt_busy, cnt_lb, cnt_ov, cnt_done);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        @(posedge clk1); #1;
        drive_cfg(5, 1, 1, 1, 1);
        start = 1'b1;
        push_layer(5, 1, 1, 1, 1);
        clr_cnt();
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout1: got no done want done"); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_busy: got %b want 0", busy); end
        @(negedge clk1);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
        n_chk++;
        if (cnt_busy != 34 || cnt_done != 1 || wq.size() != 0 || pq.size() != 0) begin
            n_fail++; $display("FAIL b2b_run1 busy/done/wq/pq: got %0d/%0d/%0d/%0d want 34/1/0/0",
                               cnt_busy, cnt_done, wq.size(), pq.size());
        end
        push_layer(5, 1, 1, 1, 1);
        clr_cnt();
        @(negedge clk1);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        start = 1'b0;
        wait_done(200, to);
        n_chk++;
        if (to) begin n_fail++; $display("FAIL b2b_timeout2: got no done want done"); end
        @(negedge clk1);
        n_chk++;
        if (cnt_busy != 34 || cnt_lb != 25 || cnt_done != 1) begin
            n_fail++; $display("FAIL b2b_run2 busy/lb/done: got %0d/%0d/%0d want 34/25/1",
                               cnt_busy, cnt_lb, cnt_done);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        drive_cfg(0, 0, 0, 0, 0);
        clr_cnt();
        test_reset();
        test_basic();
        test_multi_channel();
        test_stall();
        test_cfg_err();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_ctrl_v2.md
Name: conv_ctrl_v2

Overview:
Second-generation convolution sequencer for the CNN accelerator datapath.
- Takes layer geometry (padded IFM size, stride, pad, input/output channel counts) as runtime config latched on start, instead of fixed elaboration parameters.
- Issues weight-load, IFM-read, line-buffer and window/accumulate strobes on a single clock domain.
- Adds a start/busy/done handshake and a stall input so the array can be back-pressured by the output path.

Parameters:
KERNEL_SIZE, 3, kernel edge K; fixed per instance.
MAX_IFM, 64, maximum padded IFM edge supported.
MAX_CH, 256, maximum CI and CO.
DIM_W, 7, width of size/row/col fields; must satisfy 2^DIM_W > MAX_IFM.
CH_W, 9, width of channel fields; must satisfy 2^CH_W > MAX_CH.

Ports:
- clk1  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  start request; sampled in IDLE only
- cfg_ifm_size  in  DIM_W  padded IFM edge S
- cfg_stride  in  3  stride, 1..7
- cfg_pad  in  3  pad width P
- cfg_ci  in  CH_W  input channels
- cfg_co  in  CH_W  output filters
- stall  in  1  freeze sequencing
- busy  out  1  high from accept until done
- done  out  1  one-cycle end-of-layer pulse
- cfg_err  out  1  sticky invalid-config flag
- wgt_read  out  1  weight fetch strobe
- set_wgt  out  K*K  one-hot weight register select
- ifm_read  out  1  fetch real (non-pad) pixel
- lb_wr_en  out  1  line-buffer write strobe
- lb_wr_sel  out  K  one-hot line-buffer row select
- win_valid  out  1  full KxK window present at current stride point
- acc_clr  out  1  first-channel window: load, do not accumulate
- out_valid  out  1  last-channel window: result complete

Behaviour:
- Reset (asynchronous, active low, rst_n) forces state IDLE, all counters 0, and every output 0. Assertion mid-layer aborts immediately; no done pulse is produced.
- State machine: IDLE, WLOAD, COMPUTE, DONE.
- IDLE -> WLOAD on start with a valid config. Config is latched that cycle; busy=1 from the next cycle.
- Invalid config leaves the FSM in IDLE and sets cfg_err. cfg_err clears on the next valid start.
- Valid config requires all of: K <= S <= MAX_IFM; stride >= 1; 2P < S; 1 <= ci, co <= MAX_CH.
- start while busy is ignored.
- WLOAD lasts K*K non-stalled cycles.
  - set_wgt holds bit i on load cycle i; wgt_read=1 on every load cycle.
  - Then -> COMPUTE with row=col=0 and lb_wr_sel=bit0.
- COMPUTE scans S*S positions in raster order; col wraps at S-1 and increments row.
  - lb_wr_en=1 each non-stalled cycle.
  - lb_wr_sel rotates left one position when col wraps.
  - ifm_read=1 when P <= row < S-P and P <= col < S-P; pad positions drive zero downstream.
  - win_valid=1 when row >= K-1, col >= K-1, and (row-K+1) and (col-K+1) are both multiples of stride. Implemented with stride phase counters, no divider.
  - acc_clr = win_valid when ch==0; out_valid = win_valid when ch==ci-1 (both when ci==1).
- End of channel (row=col=S-1):
  - If ch < ci-1: ch++ and -> WLOAD.
  - Else if flt < co-1: ch=0, flt++ and -> WLOAD.
  - Else -> DONE.
- DONE: done=1 and busy=0 for one cycle, then -> IDLE. start is not accepted in the DONE cycle.
- stall=1 freezes state, counters and set_wgt, and forces every strobe (wgt_read, ifm_read, lb_wr_en, win_valid, acc_clr, out_valid) to 0 that cycle. Sequencing resumes exactly where it stopped.
- Stall in IDLE or DONE has no effect.
- All strobes are registered and aligned with the counter values they describe: one cycle after the position is reached, zero combinational path from inputs.
- Cycle count without stall: busy cycles = co*ci*(K*K + S*S).
- Windows per filter per channel: OH^2, where OH = (S-K)/stride + 1 (integer division).

Optional Feature:
STALL_CNT_EN
- Defined: adds output stall_cnt[31:0], counting cycles with busy=1 and stall=1. Cleared on accepted start, held after done, saturates at all-ones.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. K=3, S=5, stride 1, P=1, ci=1, co=1, no stall -> busy 34 cycles; 9 wgt_read; 25 lb_wr_en; 9 ifm_read; 9 out_valid each with acc_clr; single done.
2. K=3, S=7, stride 2, ci=2, co=2 -> 4 passes of 9+49 cycles (232 busy); 9 win_valid per pass; acc_clr only on ch0 passes; out_valid only on ch1 passes; 18 out_valid total.
3. Config 1 with stall asserted 5 cycles mid-row -> no strobes while stalled, totals unchanged, busy 39 cycles; with STALL_CNT_EN, stall_cnt=5.
4. start with cfg_ifm_size=2 (< K) -> cfg_err=1, busy stays 0; next valid start -> cfg_err=0, normal run.
5. rst_n low during COMPUTE -> all outputs 0 asynchronously, no done; a new start after release runs a full config 1 layer correctly.
6. start held high through a whole run plus the DONE cycle -> a new run is accepted only on the cycle after DONE; lb_wr_sel sequence 001,010,100,001,010 per channel.
